// File: rtl/ps2_key_decoder_if.sv
// Byte handshake between the PS/2 receiver FIFO and the scan-code decoder.
// The receiver (master) presents the FIFO head and status; the decoder
// (slave) pops bytes with the active-low nextdata_n strobe.
interface ps2_key_decoder_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;

  modport master (
    output ps2_data,
    output ps2_ready,
    output ps2_overflow,
    input  ps2_nextdata_n
  );

  modport slave (
    input  ps2_data,
    input  ps2_ready,
    input  ps2_overflow,
    output ps2_nextdata_n
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: pops bytes from the PS/2 receiver FIFO, folds the
// E0 (extended) and F0 (break) prefixes into key events, flags typematic
// repeats of the held key, counts new presses and maps codes to ASCII.
module ps2_key_decoder (
  input  logic                     clock,
  input  logic                     reset,
  ps2_key_decoder_if.slave         rx,
  output logic                     key_valid,
  output logic [7:0]               key_code,
  output logic                     key_ext,
  output logic                     key_release,
  output logic                     key_repeat,
  output logic                     key_held,
  output logic [7:0]               key_ascii,
  output logic [7:0]               press_count,
  output logic                     err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  state_t     state_q,       state_d;
  logic [7:0] byte_q,        byte_d;
  logic       ext_pend_q,    ext_pend_d;
  logic       brk_pend_q,    brk_pend_d;
  logic       key_valid_q,   key_valid_d;
  logic [7:0] key_code_q,    key_code_d;
  logic       key_ext_q,     key_ext_d;
  logic       key_release_q, key_release_d;
  logic       key_repeat_q,  key_repeat_d;
  logic       key_held_q,    key_held_d;
  logic [7:0] held_code_q,   held_code_d;
  logic       held_ext_q,    held_ext_d;
  logic [7:0] press_count_q, press_count_d;
  logic       err_q,         err_d;
  logic       same_as_held;

  // Set-2 make code to ASCII; unmapped codes give 0x00.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43;
      8'h23: return 8'h44; 8'h24: return 8'h45; 8'h2B: return 8'h46;
      8'h34: return 8'h47; 8'h33: return 8'h48; 8'h43: return 8'h49;
      8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
      8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F;
      8'h4D: return 8'h50; 8'h15: return 8'h51; 8'h2D: return 8'h52;
      8'h1B: return 8'h53; 8'h2C: return 8'h54; 8'h3C: return 8'h55;
      8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
      8'h35: return 8'h59; 8'h1A: return 8'h5A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
      8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
      8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  assign same_as_held = key_held_q && (held_code_q == byte_q) && (held_ext_q == ext_pend_q);

  // Next-state: pop handshake sequencing, prefix folding and held-key tracking.
  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    byte_d        = byte_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_repeat_d  = key_repeat_q;
    key_held_d    = key_held_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_count_d = press_count_q;
    err_d         = err_q | rx.ps2_overflow;

    case (state_q)
      ST_IDLE: begin
        if (rx.ps2_ready) begin
          byte_d  = rx.ps2_data;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        state_d = ST_SETTLE;
        if (byte_q == CODE_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == CODE_BREAK) begin
          brk_pend_d = 1'b1;
        end else if (byte_q == CODE_PAUSE) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          key_valid_d   = 1'b1;
          key_code_d    = byte_q;
          key_ext_d     = ext_pend_q;
          key_release_d = brk_pend_q;
          ext_pend_d    = 1'b0;
          brk_pend_d    = 1'b0;
          if (brk_pend_q) begin
            key_repeat_d = 1'b0;
            if (same_as_held) key_held_d = 1'b0;
          end else if (same_as_held) begin
            key_repeat_d = 1'b1;
          end else begin
            key_repeat_d  = 1'b0;
            key_held_d    = 1'b1;
            held_code_d   = byte_q;
            held_ext_d    = ext_pend_q;
            press_count_d = press_count_q + 8'd1;
          end
        end
      end

      ST_SETTLE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any half-received prefix.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      byte_q        <= 8'h00;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_held_q    <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      press_count_q <= 8'h00;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_repeat_q  <= key_repeat_d;
      key_held_q    <= key_held_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
    end
  end

  // Pop strobe is decoded straight from the state so reset releases it at once.
  assign rx.ps2_nextdata_n = (state_q != ST_POP);

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_repeat  = key_repeat_q;
  assign key_held    = key_held_q;
  assign press_count = press_count_q;
  assign err         = err_q;
  assign key_ascii   = key_ext_q ? 8'h00 : scan_to_ascii(key_code_q);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a queue models the receiver FIFO,
// decoded events are captured on the falling edge and compared to
// hand-computed expectations.
module tb_ps2_key_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic       key_held;
  logic [7:0] key_ascii;
  logic [7:0] press_count;
  logic       err;

  ps2_key_decoder_if rx_if ();

  ps2_key_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx_if.slave),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .key_held    (key_held),
    .key_ascii   (key_ascii),
    .press_count (press_count),
    .err         (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic       held;
    logic [7:0] count;
    logic [7:0] ascii;
  } ev_t;

  logic [7:0] fifo[$];
  ev_t        evq[$];
  int         lows[$];
  int         cycle      = 0;
  int         viol       = 0;
  logic       pop_pending = 1'b0;
  int         n_checks   = 0;
  int         n_errors   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Falling-edge monitor: pop strobes, handshake violations and events.
  always @(negedge clock) begin
    ev_t e;
    cycle++;
    pop_pending = !rx_if.ps2_nextdata_n;
    if (!rx_if.ps2_nextdata_n) begin
      lows.push_back(cycle);
      if (!rx_if.ps2_ready) viol++;
    end
    if (key_valid) begin
      e.code = key_code; e.ext = key_ext; e.rel = key_release; e.rep = key_repeat;
      e.held = key_held; e.count = press_count; e.ascii = key_ascii;
      evq.push_back(e);
    end
  end

  // Receiver FIFO model: pop after a sampled strobe, then present the head.
  always @(posedge clock) begin
    #1;
    if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
    rx_if.ps2_ready = (fifo.size() > 0);
    rx_if.ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (fifo.size() != 0 || rx_if.ps2_ready); i++) @(posedge clock);
    repeat (4) @(posedge clock);
    check("drain_timeout", fifo.size(), 0);
  endtask

  task automatic check_ev(input string tag, input int idx, input logic [7:0] code,
                          input logic ext, input logic rel, input logic rep,
                          input logic held, input logic [7:0] count, input logic [7:0] ascii);
    if (idx >= evq.size()) begin
      check({tag, "_missing"}, 0, 1);
    end else begin
      check({tag, "_code"},  evq[idx].code,  code);
      check({tag, "_ext"},   evq[idx].ext,   ext);
      check({tag, "_rel"},   evq[idx].rel,   rel);
      check({tag, "_rep"},   evq[idx].rep,   rep);
      check({tag, "_held"},  evq[idx].held,  held);
      check({tag, "_count"}, evq[idx].count, count);
      check({tag, "_ascii"}, evq[idx].ascii, ascii);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int  base;
    int  lbase;
    bit  found;

    reset = 1'b1;
    rx_if.ps2_overflow = 1'b0;
    rx_if.ps2_ready    = 1'b0;
    rx_if.ps2_data     = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_nextdata_n", rx_if.ps2_nextdata_n, 1);
    check("rst_valid",      key_valid,   0);
    check("rst_code",       key_code,    0);
    check("rst_held",       key_held,    0);
    check("rst_count",      press_count, 0);
    check("rst_err",        err,         0);
    check("rst_ascii",      key_ascii,   0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Make then break of 'A'.
    base = evq.size();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(100);
    check("mb_events", evq.size() - base, 2);
    check_ev("mb_make",  base,     8'h1C, 0, 0, 0, 1, 8'd1, 8'h41);
    check_ev("mb_break", base + 1, 8'h1C, 0, 1, 0, 0, 8'd1, 8'h41);

    // Extended key make and break.
    base = evq.size();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain(100);
    check("ext_events", evq.size() - base, 2);
    check_ev("ext_make",  base,     8'h75, 1, 0, 0, 1, 8'd2, 8'h00);
    check_ev("ext_break", base + 1, 8'h75, 1, 1, 0, 0, 8'd2, 8'h00);

    // Typematic repeat of '1', then release.
    base = evq.size();
    push(8'h16); push(8'h16); push(8'h16); push(8'hF0); push(8'h16);
    drain(100);
    check("typ_events", evq.size() - base, 4);
    check_ev("typ_0",   base,     8'h16, 0, 0, 0, 1, 8'd3, 8'h31);
    check_ev("typ_1",   base + 1, 8'h16, 0, 0, 1, 1, 8'd3, 8'h31);
    check_ev("typ_2",   base + 2, 8'h16, 0, 0, 1, 1, 8'd3, 8'h31);
    check_ev("typ_brk", base + 3, 8'h16, 0, 1, 0, 0, 8'd3, 8'h31);

    // Break of a key other than the held one keeps the held key.
    base = evq.size();
    push(8'h1C); push(8'hF0); push(8'h32); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(100);
    check("oth_events", evq.size() - base, 4);
    check_ev("oth_make",  base,     8'h1C, 0, 0, 0, 1, 8'd4, 8'h41);
    check_ev("oth_brk32", base + 1, 8'h32, 0, 1, 0, 1, 8'd4, 8'h42);
    check_ev("oth_rep",   base + 2, 8'h1C, 0, 0, 1, 1, 8'd4, 8'h41);
    check_ev("oth_brk1c", base + 3, 8'h1C, 0, 1, 0, 0, 8'd4, 8'h41);

    // E1 discards pending prefixes.
    base = evq.size();
    push(8'hE0); push(8'hE1); push(8'h5A); push(8'hF0); push(8'h5A);
    push(8'hF0); push(8'hE1); push(8'h29); push(8'hF0); push(8'h29);
    drain(150);
    check("e1_events", evq.size() - base, 4);
    check_ev("e1_enter",     base,     8'h5A, 0, 0, 0, 1, 8'd5, 8'h0D);
    check_ev("e1_enter_brk", base + 1, 8'h5A, 0, 1, 0, 0, 8'd5, 8'h0D);
    check_ev("e1_space",     base + 2, 8'h29, 0, 0, 0, 1, 8'd6, 8'h20);
    check_ev("e1_space_brk", base + 3, 8'h29, 0, 1, 0, 0, 8'd6, 8'h20);
    @(negedge clock);
    check("hold_code",    key_code,    8'h29);
    check("hold_release", key_release, 1);
    check("hold_valid",   key_valid,   0);

    // Handshake: four bytes queued back to back.
    base  = evq.size();
    lbase = lows.size();
    push(8'h1A); push(8'h1A); push(8'hF0); push(8'h1A);
    drain(100);
    check("hs_pops", lows.size() - lbase, 4);
    for (int i = 1; i < 4; i++) begin
      if (lbase + i < lows.size()) check($sformatf("hs_gap%0d", i), lows[lbase + i] - lows[lbase + i - 1], 3);
    end
    check("hs_events", evq.size() - base, 3);
    check_ev("hs_make", base, 8'h1A, 0, 0, 0, 1, 8'd7, 8'h5A);
    check("hs_no_pop_when_empty", viol, 0);

    // Overflow makes err sticky.
    @(negedge clock);
    rx_if.ps2_overflow = 1'b1;
    @(negedge clock);
    rx_if.ps2_overflow = 1'b0;
    @(negedge clock);
    check("ovf_err_set", err, 1);
    repeat (5) @(negedge clock);
    check("ovf_err_sticky", err, 1);

    // Reset during POP of an F0 prefix.
    push(8'hF0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (!rx_if.ps2_nextdata_n) found = 1'b1;
    end
    check("rst_pop_seen", found, 1);
    #1 reset = 1'b1;
    #1 check("rst_pop_release", rx_if.ps2_nextdata_n, 1);
    repeat (2) @(negedge clock);
    check("rst_mid_code",  key_code,    0);
    check("rst_mid_held",  key_held,    0);
    check("rst_mid_count", press_count, 0);
    check("rst_mid_err",   err,         0);
    check("rst_mid_rel",   key_release, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    base = evq.size();
    push(8'h1C);
    drain(100);
    check("post_rst_events", evq.size() - base, 1);
    check_ev("post_rst", base, 8'h1C, 0, 0, 0, 1, 8'd1, 8'h41);

    // Counter wrap: 256 alternating makes with breaks.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h32);
      push(8'hF0);
      push((i % 2 == 0) ? 8'h1C : 8'h32);
    end
    drain(3000);
    check("wrap_255", press_count, 8'd255);
    push(8'h32); push(8'hF0); push(8'h32);
    drain(100);
    check("wrap_0", press_count, 8'd0);
    check("wrap_held", key_held, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes raw set-2 scan-code bytes from the `ps2_keyboard` receiver FIFO and turns them into key events. It pops one byte at a time through the receiver's `ready`/`nextdata_n` handshake and handles the `E0` extended prefix and the `F0` break prefix. It tracks the currently held key so typematic repeats are flagged, and maintains a press counter. Its outputs feed the `ledr`/seven-segment display logic in the top level.

## Interface
Reset is asynchronous and active-high. The block has one clock. Ports are `clock` and `reset`.

Parameters:
- none

Ports:
- `clock` — input, 1 bit. System clock, same domain as `ps2_keyboard`.
- `reset` — input, 1 bit. Asynchronous, active-high.
- `ps2_data` — input, 8 bits. Byte at the receiver FIFO head. Valid while `ps2_ready` is 1.
- `ps2_ready` — input, 1 bit. Receiver FIFO is non-empty.
- `ps2_overflow` — input, 1 bit. Receiver FIFO overflowed.
- `ps2_nextdata_n` — output, 1 bit. Active-low pop. Held low for exactly one cycle per consumed byte.
- `key_valid` — output, 1 bit. One-cycle pulse per decoded key event.
- `key_code` — output, 8 bits. Scan code of the last event, without prefixes.
- `key_ext` — output, 1 bit. Last event was `E0`-prefixed.
- `key_release` — output, 1 bit. Last event was a break (`F0`-prefixed).
- `key_repeat` — output, 1 bit. Last event was a typematic repeat of the held key.
- `key_held` — output, 1 bit. A key is currently held.
- `key_ascii` — output, 8 bits. ASCII value of `key_code`, or 0x00 if the code is not mapped.
- `press_count` — output, 8 bits. Count of new (non-repeat) make events, modulo 256.
- `err` — output, 1 bit. Sticky flag. Set while `ps2_overflow` was seen high.

## Operation
FSM states:
- **IDLE**: `ps2_nextdata_n`=1. If `ps2_ready`=1, latch `ps2_data` into `byte_r` and go to POP.
- **POP**: `ps2_nextdata_n`=0, driven combinationally from the state. Decode `byte_r` on this cycle's edge, then go to SETTLE.
- **SETTLE**: `ps2_nextdata_n`=1. Wait one cycle so the receiver's read pointer and `ready` update, then go to IDLE.

Decode rules, applied in POP to `byte_r`:
- `E0`: set `ext_pend`. No event.
- `F0`: set `brk_pend`. No event.
- `E1`: discard the byte and clear both pending flags. No event.
- Any other byte: emit an event.
  - `key_valid`=1.
  - `key_code`=byte.
  - `key_ext`=`ext_pend`.
  - `key_release`=`brk_pend`.
  - Clear both pending flags.

Held-key tracking uses `held_code`/`held_ext`.
- **Make, same as the held key** (`key_held`=1, code and ext equal): `key_repeat`=1. Count unchanged.
- **Make, any other case**: `key_repeat`=0, `held_*` ← this key, `key_held`=1, `press_count` += 1 (255 wraps to 0).
- **Break matching the held key**: `key_held`=0.
- **Break of a different key**: event emitted, `key_held` unchanged. `key_repeat`=0 on every break.

`key_ascii` is combinational from the registered `key_code`/`key_ext`:
- `key_ext`=1 gives 0x00.
- Letters A–Z map to uppercase 0x41–0x5A, e.g. `1C`→0x41, `32`→0x42, `1A`→0x5A.
- Digits: `45`→0x30, `16`→0x31, `1E`→0x32, `26`→0x33, `25`→0x34, `2E`→0x35, `36`→0x36, `3D`→0x37, `3E`→0x38, `46`→0x39.
- `29`→0x20. `5A`→0x0D. All other codes give 0x00.

Overflow handling: `ps2_overflow`=1 in any cycle sets `err`, which stays set until reset. Bytes are still consumed normally.

## Timing
- Reset values: state IDLE, `ps2_nextdata_n`=1, all other outputs 0, `held_*`=0, pending flags 0.
- Reset is asynchronous. Asserting it mid-sequence, including during POP, forces `ps2_nextdata_n` high immediately and drops any half-received prefix.
- Latency: with `ps2_ready` high at edge N in IDLE, `ps2_nextdata_n` is low during cycle N+1 (POP). Event outputs are updated at edge N+2 and visible during SETTLE.
- `key_valid` is high for exactly that one cycle.
- Throughput is at most one byte per 3 cycles.
- `ps2_ready` is sampled only in IDLE. Its value during SETTLE is ignored.
- `key_code`/`key_ext`/`key_release`/`key_repeat` hold their values between events.
- A prefix byte followed by an empty FIFO leaves the pending flags set indefinitely.

## Test plan
- **Make then break**: feed `1C`, `F0`, `1C`.
  - Two `key_valid` pulses.
  - First pulse: code 0x1C, ascii 0x41, release 0, `press_count`=1, `key_held`=1.
  - Second pulse: release 1, `key_held`=0.
- **Extended key**: feed `E0 75`, then `E0 F0 75`.
  - Events have ext=1 and ascii 0x00.
  - The break clears `key_held`.
  - Exactly one pulse per 2–3 bytes; none for the prefixes.
- **Typematic**: feed `16 16 16`.
  - Three pulses with repeat = 0, 1, 1.
  - `press_count`=1, ascii 0x31.
- **Counter wrap**: 256 alternating makes of `1C`/`32` with breaks in between → `press_count` returns to 0x00.
- **Handshake**: hold `ps2_ready`=1 with 4 bytes queued.
  - `ps2_nextdata_n` is low for exactly 4 single cycles, spaced 3 cycles apart.
  - It never goes low while `ps2_ready`=0.
- **Reset/overflow**:
  - Pulse `ps2_overflow` → `err`=1 sticky.
  - Feed `F0` then assert `reset` mid-POP → all outputs 0. A following `1C` yields release=0.
